// File: rtl/register_file_mp_pkg.sv
// rtl/register_file_mp_pkg.sv - shared defaults and pointer-width helper for register_file_mp
package register_file_mp_pkg;
    localparam int RF_REG_WIDTH  = 16;
    localparam int RF_REG_COUNT  = 16;
    localparam int RF_READ_PORTS = 3;

    function automatic int rf_ptr_width(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write scoreboard: busy_vec, issue_conflict and rd_busy
module rf_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int REG_COUNT  = RF_REG_COUNT,
    parameter int PTR_W      = rf_ptr_width(REG_COUNT),
    parameter int READ_PORTS = RF_READ_PORTS,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr0_en,
    input  logic [PTR_W-1:0]              wr0_ptr,
    input  logic                          wr1_en,
    input  logic [PTR_W-1:0]              wr1_ptr,
    input  logic                          issue_en,
    input  logic [PTR_W-1:0]              issue_ptr,
    input  logic [READ_PORTS*PTR_W-1:0]   rd_ptr,
    output logic [READ_PORTS-1:0]         rd_busy,
    output logic [REG_COUNT-1:0]          busy_vec,
    output logic                          issue_conflict
);
    logic [REG_COUNT-1:0] clear_vec;
    logic [REG_COUNT-1:0] set_vec;
    logic [REG_COUNT-1:0] busy_next;
    logic                 conflict_next;

    // Any write clears, even the losing one on a dual-port collision.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            clear_vec[i] = (wr0_en && wr0_ptr == PTR_W'(i)) || (wr1_en && wr1_ptr == PTR_W'(i));
            set_vec[i]   = issue_en && issue_ptr == PTR_W'(i);
        end
        busy_next     = (busy_vec & ~clear_vec) | set_vec;
        conflict_next = issue_en && busy_vec[issue_ptr] && !clear_vec[issue_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_vec       <= '0;
            issue_conflict <= 1'b0;
        end else begin
            busy_vec       <= busy_next;
            issue_conflict <= conflict_next;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd_busy
        logic [PTR_W-1:0] ptr;
        assign ptr = rd_ptr[k*PTR_W +: PTR_W];
        if (BYPASS != 0) begin : g_byp
            assign rd_busy[k] = busy_vec[ptr] & ~clear_vec[ptr];
        end else begin : g_reg
            assign rd_busy[k] = busy_vec[ptr];
        end
    end
endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with two prioritised write ports and bypass
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int REG_WIDTH  = RF_REG_WIDTH,
    parameter int REG_COUNT  = RF_REG_COUNT,
    parameter int PTR_W      = rf_ptr_width(REG_COUNT),
    parameter int READ_PORTS = RF_READ_PORTS,
    parameter int BYPASS     = 1
) (
    input  logic                              clk,
    input  logic                              reset_RF,
    input  logic                              init_R0,
    input  logic [REG_WIDTH-1:0]              init_R0_data,
    input  logic [READ_PORTS*PTR_W-1:0]       rd_ptr,
    output logic [READ_PORTS*REG_WIDTH-1:0]   rd_data,
    output logic [READ_PORTS-1:0]             rd_busy,
    input  logic                              wr0_en,
    input  logic [PTR_W-1:0]                  wr0_ptr,
    input  logic [REG_WIDTH-1:0]              wr0_data,
    input  logic                              wr1_en,
    input  logic [PTR_W-1:0]                  wr1_ptr,
    input  logic [REG_WIDTH-1:0]              wr1_data,
    input  logic                              issue_en,
    input  logic [PTR_W-1:0]                  issue_ptr,
    output logic [REG_COUNT-1:0]              busy_vec,
    output logic                              issue_conflict
);
    logic [REG_WIDTH-1:0] regs      [REG_COUNT];
    logic [REG_WIDTH-1:0] next_regs [REG_COUNT];

    // Later assignments win: wr0 < wr1 < init_R0. The same values feed the bypass.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            next_regs[i] = regs[i];
            if (wr0_en && wr0_ptr == PTR_W'(i)) next_regs[i] = wr0_data;
            if (wr1_en && wr1_ptr == PTR_W'(i)) next_regs[i] = wr1_data;
        end
        if (init_R0) next_regs[0] = init_R0_data;
    end

    always_ff @(posedge clk) begin
        if (reset_RF) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            regs <= next_regs;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [PTR_W-1:0] ptr;
        assign ptr = rd_ptr[k*PTR_W +: PTR_W];
        if (BYPASS != 0) begin : g_byp
            assign rd_data[k*REG_WIDTH +: REG_WIDTH] = next_regs[ptr];
        end else begin : g_reg
            assign rd_data[k*REG_WIDTH +: REG_WIDTH] = regs[ptr];
        end
    end

    rf_scoreboard #(
        .REG_COUNT  (REG_COUNT),
        .PTR_W      (PTR_W),
        .READ_PORTS (READ_PORTS),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset_RF),
        .wr0_en         (wr0_en),
        .wr0_ptr        (wr0_ptr),
        .wr1_en         (wr1_en),
        .wr1_ptr        (wr1_ptr),
        .issue_en       (issue_en),
        .issue_ptr      (issue_ptr),
        .rd_ptr         (rd_ptr),
        .rd_busy        (rd_busy),
        .busy_vec       (busy_vec),
        .issue_conflict (issue_conflict)
    );
endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp, bypass and registered-read builds
module tb_register_file_mp;
    typedef logic [15:0][15:0] regs_t;

    logic        clk = 1'b0;
    logic        reset_RF;
    logic        init_R0;
    logic [15:0] init_R0_data;
    logic [11:0] rd_ptr;
    logic        wr0_en, wr1_en, issue_en;
    logic [3:0]  wr0_ptr, wr1_ptr, issue_ptr;
    logic [15:0] wr0_data, wr1_data;

    logic [47:0] rd_data_b, rd_data_n;
    logic [2:0]  rd_busy_b, rd_busy_n;
    logic [15:0] busy_vec_b, busy_vec_n;
    logic        conflict_b, conflict_n;

    int n_tests = 0;
    int n_fails = 0;
    logic check_en = 1'b0;

    regs_t       model_r;
    logic [15:0] model_busy;
    logic        model_conf;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .reset_RF(reset_RF), .init_R0(init_R0), .init_R0_data(init_R0_data),
        .rd_ptr(rd_ptr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_ptr(wr0_ptr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_ptr(wr1_ptr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_ptr(issue_ptr),
        .busy_vec(busy_vec_b), .issue_conflict(conflict_b)
    );

    register_file_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .reset_RF(reset_RF), .init_R0(init_R0), .init_R0_data(init_R0_data),
        .rd_ptr(rd_ptr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr0_en(wr0_en), .wr0_ptr(wr0_ptr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_ptr(wr1_ptr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_ptr(issue_ptr),
        .busy_vec(busy_vec_n), .issue_conflict(conflict_n)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic regs_t after_writes(input regs_t cur);
        regs_t r = cur;
        if (wr0_en) r[wr0_ptr] = wr0_data;
        if (wr1_en) r[wr1_ptr] = wr1_data;
        if (init_R0) r[0] = init_R0_data;
        return r;
    endfunction

    function automatic logic writes_to(input logic [3:0] p);
        return (wr0_en && wr0_ptr == p) || (wr1_en && wr1_ptr == p);
    endfunction

    function automatic logic [15:0] busy_after(input logic [15:0] cur);
        logic [15:0] b = cur;
        if (wr0_en) b[wr0_ptr] = 1'b0;
        if (wr1_en) b[wr1_ptr] = 1'b0;
        if (issue_en) b[issue_ptr] = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset_RF) begin
            model_r    <= '0;
            model_busy <= '0;
            model_conf <= 1'b0;
        end else begin
            model_r    <= after_writes(model_r);
            model_busy <= busy_after(model_busy);
            model_conf <= issue_en && model_busy[issue_ptr] && !writes_to(issue_ptr);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            regs_t nxt;
            nxt = after_writes(model_r);
            for (int k = 0; k < 3; k++) begin
                logic [3:0] p;
                p = rd_ptr[k*4 +: 4];
                check($sformatf("bypass rd_data[%0d]", k), 64'(rd_data_b[k*16 +: 16]), 64'(nxt[p]));
                check($sformatf("registered rd_data[%0d]", k), 64'(rd_data_n[k*16 +: 16]), 64'(model_r[p]));
                check($sformatf("bypass rd_busy[%0d]", k), 64'(rd_busy_b[k]), 64'(model_busy[p] && !writes_to(p)));
                check($sformatf("registered rd_busy[%0d]", k), 64'(rd_busy_n[k]), 64'(model_busy[p]));
            end
            check("busy_vec bypass", 64'(busy_vec_b), 64'(model_busy));
            check("busy_vec registered", 64'(busy_vec_n), 64'(model_busy));
            check("issue_conflict bypass", 64'(conflict_b), 64'(model_conf));
            check("issue_conflict registered", 64'(conflict_n), 64'(model_conf));
        end
    end

    task automatic idle();
        reset_RF = 1'b0; init_R0 = 1'b0; init_R0_data = '0;
        wr0_en = 1'b0; wr0_ptr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_ptr = '0; wr1_data = '0;
        issue_en = 1'b0; issue_ptr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        rd_ptr = '0;
        reset_RF = 1'b1;
        step();
        check_en = 1'b1;

        // reset state, ports read 0,1,2
        idle();
        rd_ptr = {4'd2, 4'd1, 4'd0};
        mid();
        check("lit reset rd_data b", 64'(rd_data_b), 64'h0);
        check("lit reset rd_data n", 64'(rd_data_n), 64'h0);
        check("lit reset busy_vec", 64'(busy_vec_b), 64'h0);
        check("lit reset conflict", 64'(conflict_b), 64'h0);
        step();

        // single write with same-cycle read
        wr0_en = 1'b1; wr0_ptr = 4'd5; wr0_data = 16'h1234;
        rd_ptr = {4'd5, 4'd5, 4'd5};
        mid();
        check("lit wr0 bypass now", 64'(rd_data_b), 64'h1234_1234_1234);
        check("lit wr0 registered now", 64'(rd_data_n), 64'h0);
        step();
        idle();
        mid();
        check("lit wr0 registered next", 64'(rd_data_n), 64'h1234_1234_1234);
        step();

        // both write ports collide: wr1 wins
        wr0_en = 1'b1; wr0_ptr = 4'd3; wr0_data = 16'hAAAA;
        wr1_en = 1'b1; wr1_ptr = 4'd3; wr1_data = 16'h5555;
        rd_ptr = {4'd3, 4'd5, 4'd3};
        mid();
        check("lit collide bypass", 64'(rd_data_b), 64'h5555_1234_5555);
        step();
        idle();
        mid();
        check("lit collide registered", 64'(rd_data_n), 64'h5555_1234_5555);
        step();

        // init_R0 beats a write to R0
        init_R0 = 1'b1; init_R0_data = 16'h0007;
        wr0_en = 1'b1; wr0_ptr = 4'd0; wr0_data = 16'hFFFF;
        rd_ptr = {4'd0, 4'd0, 4'd0};
        mid();
        check("lit init_R0 bypass", 64'(rd_data_b[15:0]), 64'h0007);
        step();
        idle();
        mid();
        check("lit init_R0 registered", 64'(rd_data_n[15:0]), 64'h0007);
        step();
        reset_RF = 1'b1; init_R0 = 1'b1; init_R0_data = 16'h0009;
        step();
        idle();
        mid();
        check("lit init_R0 under reset", 64'(rd_data_n[15:0]), 64'h0);
        step();

        // scoreboard set / clear / set-wins
        issue_en = 1'b1; issue_ptr = 4'd4;
        step();
        idle();
        rd_ptr = {4'd4, 4'd4, 4'd4};
        mid();
        check("lit busy after issue", 64'(busy_vec_b), 64'h0010);
        check("lit rd_busy bypass", 64'(rd_busy_b), 64'b111);
        step();
        wr1_en = 1'b1; wr1_ptr = 4'd4; wr1_data = 16'hBEEF;
        mid();
        check("lit rd_busy bypass write", 64'(rd_busy_b), 64'b000);
        check("lit rd_busy registered write", 64'(rd_busy_n), 64'b111);
        step();
        idle();
        mid();
        check("lit busy cleared", 64'(busy_vec_b), 64'h0);
        step();
        issue_en = 1'b1; issue_ptr = 4'd4;
        wr0_en = 1'b1; wr0_ptr = 4'd4; wr0_data = 16'h0101;
        step();
        issue_en = 1'b1; issue_ptr = 4'd4;
        wr1_en = 1'b1; wr1_ptr = 4'd4; wr1_data = 16'h0202;
        wr0_en = 1'b0;
        mid();
        check("lit busy set wins", 64'(busy_vec_b), 64'h0010);
        step();
        idle();
        mid();
        check("lit no conflict after clear", 64'(conflict_b), 64'h0);
        step();

        // issue_conflict pulse, then reset mid-pending
        issue_en = 1'b1; issue_ptr = 4'd6;
        step();
        step();
        idle();
        mid();
        check("lit conflict pulse", 64'(conflict_b), 64'h1);
        check("lit busy 4 and 6", 64'(busy_vec_b), 64'h0050);
        step();
        mid();
        check("lit conflict one cycle", 64'(conflict_n), 64'h0);
        step();
        reset_RF = 1'b1;
        step();
        idle();
        mid();
        check("lit busy after reset", 64'(busy_vec_n), 64'h0);
        step();

        // mixed traffic, checked against the model every cycle
        for (int n = 0; n < 200; n++) begin
            wr0_en = 1'($urandom_range(0, 1));
            wr0_ptr = 4'($urandom_range(0, 15));
            wr0_data = 16'($urandom);
            wr1_en = 1'($urandom_range(0, 1));
            wr1_ptr = 4'($urandom_range(0, 15));
            wr1_data = 16'($urandom);
            issue_en = 1'($urandom_range(0, 1));
            issue_ptr = 4'($urandom_range(0, 7));
            init_R0 = ($urandom_range(0, 9) == 0);
            init_R0_data = 16'($urandom);
            reset_RF = ($urandom_range(0, 49) == 0);
            rd_ptr = 12'($urandom);
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
